axis_hfilter3: RTL
==================

# axis_hfilter3

Synthesizable AXI-Stream image stage that applies a horizontal 3-tap [1 2 1]/4 smoothing filter to a raster pixel stream. Lines are `LINE_WIDTH` pixels long, and line edges use replication. It sits between the image VIP's master output, which supplies pixels and frame-last, and the VIP's slave input, which records results. It carries one pixel per beat, is fully back-pressurable, and drops no beats.

## Interface
- `DATA_BYTES`, default 1: bytes per beat. The whole beat is one unsigned pixel.
- `DATA_BITS`, default `DATA_BYTES*8`: pixel width.
- `LINE_WIDTH`, default 640: pixels per line. Must be at least 2.
- `COL_BITS`, default `$clog2(LINE_WIDTH)`: column counter width.

Ports:
- `clk_i`, input, 1 bit: single clock. All logic is on the rising edge.
- `rstn_i`, input, 1 bit: asynchronous, active-low reset.
- `axis_s_data_i`, input, `DATA_BITS`: input pixel.
- `axis_s_valid_i`, input, 1 bit: input beat valid.
- `axis_s_ready_o`, output, 1 bit: block accepts an input beat.
- `axis_s_last_i`, input, 1 bit: last pixel of frame.
- `axis_m_data_o`, output, `DATA_BITS`: filtered pixel.
- `axis_m_valid_o`, output, 1 bit: output beat valid.
- `axis_m_ready_i`, input, 1 bit: downstream accepts.
- `axis_m_last_o`, output, 1 bit: last filtered pixel of frame.

## Operation
- Handshakes:
  - Input beat transfers when `axis_s_valid_i && axis_s_ready_o`.
  - Output beat transfers when `axis_m_valid_o && axis_m_ready_i`.
- Registers:
  - `prev` holds p[x-1].
  - `cur` holds p[x].
  - `col` is the column counter.
  - Output register holds data, valid and last.
- `free = !axis_m_valid_o || axis_m_ready_i`. This is the output register space.
- `axis_s_ready_o = rstn_i && state != FLUSH && free`.
- State FIRST (expecting column 0):
  - On transfer, load `prev <= p` and `cur <= p` (left-edge replication), and set `col <= 1`.
  - Without `last`: go to RUN with no output.
  - With `last` (one-pixel tail): emit `p` with `last=1`, set `col <= 0`, stay in FIRST.
- State RUN (accepting column `col`):
  - On transfer, emit `(prev + 2*cur + p + 2) >> 2` for column `col-1`, with `last=0`.
  - Then shift: `prev <= cur`, `cur <= p`, `col <= col+1`.
  - Go to FLUSH if `col == LINE_WIDTH-1` or input `last=1`. Latch that `last` into `flush_last`.
- State FLUSH:
  - Accepts no input.
  - When `free`, emit `(prev + 3*cur + 2) >> 2` (right-edge replication) with `axis_m_last_o = flush_last`.
  - Then set `col <= 0` and go to FIRST.
- `last` arriving before end of line truncates the line: flush, then restart at column 0. `col` never exceeds `LINE_WIDTH-1`.
- Arithmetic:
  - Sum is computed at `DATA_BITS+2` bits, unsigned, with round-half-up (+2), then `>>2`.
  - Result always fits `DATA_BITS`; no saturation is needed.
- The output register holds data, last and valid stable while `axis_m_valid_o && !axis_m_ready_i`.

## Timing
- Reset values while `rstn_i` is low:
  - `axis_m_valid_o=0`, `axis_m_data_o=0`, `axis_m_last_o=0`, `axis_s_ready_o=0`.
  - State is FIRST, `col=0`, `prev=cur=0`, `flush_last=0`.
- Reset mid-line discards the partial line and any pending output. The first beat after reset is column 0.
- Latency: output for column x appears one cycle after input x+1 is accepted. The final pixel of a line appears one cycle after entering FLUSH, given `free`.
- Throughput is `LINE_WIDTH` outputs per `LINE_WIDTH+1` cycles under continuous valid/ready. There is one bubble per line, the FLUSH cycle.
- `axis_s_ready_o` depends combinationally on `axis_m_ready_i`. There is no skid buffer. The register-to-register path is otherwise one stage.
- Simultaneous events:
  - An output pop and a new output load in the same cycle are allowed; the register is overwritten and valid stays 1.
  - With `axis_m_ready_i=0` and the output register full, input stalls. State, `col` and registers hold.
- A new line's column 0 never mixes with the previous line's pixels, because `prev` and `cur` are reloaded in FIRST.

## Test plan
- `LINE_WIDTH=4`, `DATA_BYTES=1`, input 10,20,30,40 (last on 40), `m_ready=1`:
  - Required output 13,20,30,38, with last only on 38.
  - Second identical line: same values, one bubble between lines.
- Input 255,255,255,255 (last) -> 255,255,255,255 with no overflow.
- Back-pressure: same stimulus as the first test with `m_ready` low for 3 cycles after the 2nd output:
  - `axis_m_data_o` is held at 20 and `axis_s_ready_o=0` during the stall.
  - Final sequence is unchanged: 13,20,30,38.
- Early last, `LINE_WIDTH=4`: input 8,8,16 (last on 16) -> 8,10,14 with last on 14. The next input is treated as column 0.
- Single-pixel tail: in FIRST, input 77 with last -> output 77 with last=1, and no FLUSH cycle.
- Reset mid-line: after 2 pixels, pulse `rstn_i` low.
  - Outputs go to 0 and valid goes to 0 asynchronously.
  - Then 10,20,30,40 (last) -> 13,20,30,38.

Source files
------------

// File: rtl/axis_hfilter3.sv
// Horizontal [1 2 1]/4 smoothing filter for an AXI-Stream raster, one pixel per beat,
// with edge replication at both ends of every line and a single-entry output register.
module axis_hfilter3 #(
    parameter int DATA_BYTES = 1,
    parameter int DATA_BITS  = DATA_BYTES * 8,
    parameter int LINE_WIDTH = 640,
    parameter int COL_BITS   = $clog2(LINE_WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [DATA_BITS-1:0] axis_s_data_i,
    input  logic                 axis_s_valid_i,
    output logic                 axis_s_ready_o,
    input  logic                 axis_s_last_i,
    output logic [DATA_BITS-1:0] axis_m_data_o,
    output logic                 axis_m_valid_o,
    input  logic                 axis_m_ready_i,
    output logic                 axis_m_last_o
);

    localparam int SUM_BITS = DATA_BITS + 2;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_BITS-1:0]  prev_q, prev_d;
    logic [DATA_BITS-1:0]  cur_q, cur_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic                  flush_last_q, flush_last_d;
    logic [DATA_BITS-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;

    logic                  free;
    logic                  in_xfer;
    logic                  col_at_end;
    logic [SUM_BITS-1:0]   sum_run;
    logic [SUM_BITS-1:0]   sum_flush;

    assign free           = !out_valid_q || axis_m_ready_i;
    assign axis_s_ready_o = rstn_i && (state_q != ST_FLUSH) && free;
    assign in_xfer        = axis_s_valid_i && axis_s_ready_o;
    assign col_at_end     = (col_q == COL_BITS'(LINE_WIDTH - 1));

    assign axis_m_data_o  = out_data_q;
    assign axis_m_valid_o = out_valid_q;
    assign axis_m_last_o  = out_last_q;

    // Two guard bits hold the worst case 4*max+2 without wrapping.
    assign sum_run   = SUM_BITS'(prev_q) + (SUM_BITS'(cur_q) << 1)
                     + SUM_BITS'(axis_s_data_i) + SUM_BITS'(2);
    assign sum_flush = SUM_BITS'(prev_q) + (SUM_BITS'(cur_q) << 1)
                     + SUM_BITS'(cur_q) + SUM_BITS'(2);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_FIRST;
            prev_q       <= '0;
            cur_q        <= '0;
            col_q        <= '0;
            flush_last_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cur_q        <= cur_d;
            col_q        <= col_d;
            flush_last_q <= flush_last_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FIRST: if (in_xfer && !axis_s_last_i) state_d = ST_RUN;
            ST_RUN:   if (in_xfer && (col_at_end || axis_s_last_i)) state_d = ST_FLUSH;
            ST_FLUSH: if (free) state_d = ST_FIRST;
            default:  state_d = ST_FIRST;
        endcase
    end

    always_comb begin
        prev_d       = prev_q;
        cur_d        = cur_q;
        col_d        = col_q;
        flush_last_d = flush_last_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q && !axis_m_ready_i;

        case (state_q)
            ST_FIRST: begin
                if (in_xfer) begin
                    // Both taps reload so a new line never sees the previous line's pixels.
                    prev_d = axis_s_data_i;
                    cur_d  = axis_s_data_i;
                    if (axis_s_last_i) begin
                        col_d       = '0;
                        out_data_d  = axis_s_data_i;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        col_d = COL_BITS'(1);
                    end
                end
            end
            ST_RUN: begin
                if (in_xfer) begin
                    out_data_d  = DATA_BITS'(sum_run >> 2);
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    prev_d      = cur_q;
                    cur_d       = axis_s_data_i;
                    col_d       = col_at_end ? col_q : col_q + COL_BITS'(1);
                    if (col_at_end || axis_s_last_i) begin
                        flush_last_d = axis_s_last_i;
                    end
                end
            end
            ST_FLUSH: begin
                if (free) begin
                    out_data_d  = DATA_BITS'(sum_flush >> 2);
                    out_last_d  = flush_last_q;
                    out_valid_d = 1'b1;
                    col_d       = '0;
                end
            end
            default: begin
                col_d = '0;
            end
        endcase
    end

endmodule
